// File: rtl/fft64_frame_ctrl.sv
// Frame sequencer for fft64: buffers 16 packed FIFO words, feeds 64 samples back-to-back, indexes output bins.
// Optional build macro FFT64_FRAME_CTRL_SAT_EN saturates input components to DW instead of truncating.
module fft64_frame_ctrl #(
  parameter int N     = 64,
  parameter int DW_IN = 16,
  parameter int DW    = 11,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [127:0]     rd_data,
  input  logic             rd_empty,
  output logic             rd_en,
  output logic             fft_valid_a,
  output logic [DW-1:0]    fft_ar,
  output logic [DW-1:0]    fft_ai,
  input  logic             fft_full,
  input  logic             fft_valid_o,
  input  logic [DW-1:0]    fft_xr,
  input  logic [DW-1:0]    fft_xi,
  output logic             bin_valid,
  output logic [5:0]       bin_idx,
  output logic [DW-1:0]    bin_re,
  output logic [DW-1:0]    bin_im,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             feed_err
);
  localparam int WORDS = N / 4;
  localparam int WW    = $clog2(WORDS);
  localparam int SW    = $clog2(N);

  typedef enum logic [1:0] {IDLE, FILL, WAIT, FEED} state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [SW:0]   scnt;
  logic [5:0]    bcnt;
  logic [127:0]  frame_buf [WORDS];
  logic [127:0]  cur_word;
  logic [6:0]    lane_base;
  logic [DW_IN-1:0] cur_re, cur_im;

  function automatic logic [DW-1:0] conv(input logic [DW_IN-1:0] x);
`ifdef FFT64_FRAME_CTRL_SAT_EN
    logic signed [DW_IN-1:0] sx, hi, lo;
    sx = x;
    hi = DW_IN'((1 << (DW - 1)) - 1);
    lo = ~hi;
    if (sx > hi)      conv = hi[DW-1:0];
    else if (sx < lo) conv = lo[DW-1:0];
    else              conv = sx[DW-1:0];
`else
    conv = x[DW-1:0];
`endif
  endfunction

  // Popping is gated combinationally so rd_en can never be high on an empty FIFO.
  assign rd_en = (state == FILL) && !rd_empty;
  assign busy  = (state != IDLE);

  assign cur_word  = frame_buf[scnt[SW-1:2]];
  assign lane_base = {scnt[1:0], 5'd0};
  assign cur_re    = cur_word[lane_base +: DW_IN];
  assign cur_im    = cur_word[(lane_base + 7'd16) +: DW_IN];

  always_ff @(posedge CLK) begin
    if (rd_en) frame_buf[wcnt] <= rd_data;
  end

  // Sample 0 is launched on the WAIT exit edge so it appears the cycle after fft_full falls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      wcnt        <= '0;
      scnt        <= '0;
      fft_valid_a <= 1'b0;
      fft_ar      <= '0;
      fft_ai      <= '0;
      feed_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state <= FILL;
          wcnt  <= '0;
        end
        FILL: if (!rd_empty) begin
          if (wcnt == WW'(WORDS - 1)) begin
            state <= WAIT;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        WAIT: if (!fft_full) begin
          state       <= FEED;
          fft_valid_a <= 1'b1;
          fft_ar      <= conv(cur_re);
          fft_ai      <= conv(cur_im);
          scnt        <= (SW+1)'(1);
        end
        FEED: begin
          if (fft_full) feed_err <= 1'b1;
          if (scnt == (SW+1)'(N)) begin
            fft_valid_a <= 1'b0;
            fft_ar      <= '0;
            fft_ai      <= '0;
            scnt        <= '0;
            wcnt        <= '0;
            state       <= enable ? FILL : IDLE;
          end else begin
            fft_ar <= conv(cur_re);
            fft_ai <= conv(cur_im);
            scnt   <= scnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_valid  <= 1'b0;
      bin_idx    <= '0;
      bin_re     <= '0;
      bin_im     <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      bcnt       <= '0;
    end else begin
      bin_valid  <= fft_valid_o;
      frame_done <= fft_valid_o && (bcnt == 6'd63);
      if (fft_valid_o) begin
        bin_re  <= fft_xr;
        bin_im  <= fft_xi;
        bin_idx <= bcnt;
        bcnt    <= bcnt + 1'b1;
        if (bcnt == 6'd63) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// Directed bench for fft64_frame_ctrl: FIFO model, feed/bin monitors, hand-derived expectations.
module tb_fft64_frame_ctrl;
  localparam int DW = 11;

  logic           CLK = 1'b0;
  logic           RST, enable, rd_empty = 1'b1, rd_en;
  logic [127:0]   rd_data = '0;
  logic           fft_valid_a, fft_full, fft_valid_o;
  logic [DW-1:0]  fft_ar, fft_ai, fft_xr, fft_xi, bin_re, bin_im;
  logic           bin_valid, frame_done, busy, feed_err;
  logic [5:0]     bin_idx;
  logic [15:0]    frame_cnt;

  fft64_frame_ctrl dut (
    .CLK(CLK), .RST(RST), .enable(enable), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_en(rd_en), .fft_valid_a(fft_valid_a), .fft_ar(fft_ar), .fft_ai(fft_ai),
    .fft_full(fft_full), .fft_valid_o(fft_valid_o), .fft_xr(fft_xr), .fft_xi(fft_xi),
    .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_re(bin_re), .bin_im(bin_im),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy), .feed_err(feed_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  // FIFO model: initial block owns wr_ptr, pop process owns rd_ptr.
  logic [127:0] fifo_mem [0:255];
  int wr_ptr = 0, rd_ptr = 0, viol = 0;
  bit sparse = 0, gate = 0;

  always @(negedge CLK) begin
    gate     = !gate;
    rd_data  = (rd_ptr != wr_ptr) ? fifo_mem[rd_ptr[7:0]] : '0;
    rd_empty = (rd_ptr == wr_ptr) || (sparse && gate);
  end

  always @(posedge CLK) begin
    if (rd_en && rd_empty) viol++;
    if (rd_en && !rd_empty) rd_ptr++;
  end

  int cyc = 0, feed_n = 0, runs = 0, rise_cyc = 0, bin_n = 0, fd_n = 0;
  int feed_re [0:1023];
  int feed_im [0:1023];
  int b_idx [0:255];
  int b_re [0:255];
  int b_im [0:255];
  bit b_fd [0:255];
  bit prev_va = 0;

  always @(negedge CLK) begin
    cyc++;
    if (fft_valid_a === 1'b1) begin
      if (!prev_va) begin
        runs++;
        rise_cyc = cyc;
      end
      if (feed_n < 1024) begin
        feed_re[feed_n] = $signed(fft_ar);
        feed_im[feed_n] = $signed(fft_ai);
      end
      feed_n++;
    end
    prev_va = (fft_valid_a === 1'b1);
    if (bin_valid === 1'b1) begin
      if (bin_n < 256) begin
        b_idx[bin_n] = bin_idx;
        b_re[bin_n]  = $signed(bin_re);
        b_im[bin_n]  = $signed(bin_im);
        b_fd[bin_n]  = frame_done;
      end
      bin_n++;
    end
    if (frame_done === 1'b1) fd_n++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wait_feed(input int target, input int budget, input string tag);
    int n = 0;
    while (feed_n < target && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk({tag, " feed reached"}, feed_n >= target, 1);
  endtask

  function automatic int exp_re(input int mode, input int s);
    case (mode)
      1: return s + 1;
      2: return 7 * s - 200;
      default: return s;
    endcase
  endfunction

  function automatic int exp_im(input int mode, input int s);
    case (mode)
      1: return s + 100;
      2: return -s;
      default: return 0;
    endcase
  endfunction

  task automatic push(input logic [127:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic push_frame(input int mode);
    logic [127:0] w;
    for (int wi = 0; wi < 16; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        w[32*k +: 16]      = 16'(exp_re(mode, 4*wi + k));
        w[32*k + 16 +: 16] = 16'(exp_im(mode, 4*wi + k));
      end
      push(w);
    end
  endtask

  function automatic int feed_mism(input int base, input int mode);
    int m = 0;
    for (int s = 0; s < 64; s++)
      if (feed_re[base+s] != exp_re(mode, s) || feed_im[base+s] != exp_im(mode, s)) m++;
    return m;
  endfunction

  initial begin
    int bf, br, bp, bb, bfd, pcyc, nz_re, nz_im, m;
    logic [127:0] sat_w;
    RST = 1'b0; enable = 1'b0; fft_full = 1'b0;
    fft_valid_o = 1'b0; fft_xr = '0; fft_xi = '0;
    cycles(3);
    chk("rst rd_en", rd_en, 0);
    chk("rst valid_a", fft_valid_a, 0);
    chk("rst ar", fft_ar, 0);
    chk("rst ai", fft_ai, 0);
    chk("rst bin_valid", bin_valid, 0);
    chk("rst bin_idx", bin_idx, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst busy", busy, 0);
    chk("rst feed_err", feed_err, 0);
    RST = 1'b1;
    cycles(3);
    chk("idle busy", busy, 0);

    // Impulse frame
    bf = feed_n; br = runs; bp = rd_ptr;
    for (int wi = 0; wi < 16; wi++) push(wi == 0 ? 128'h100 : 128'h0);
    enable = 1'b1;
    wait_feed(bf + 64, 300, "t1");
    cycles(3);
    nz_re = 0; nz_im = 0;
    for (int s = 1; s < 64; s++) if (feed_re[bf+s] != 0) nz_re++;
    for (int s = 0; s < 64; s++) if (feed_im[bf+s] != 0) nz_im++;
    chk("t1 pops", rd_ptr - bp, 16);
    chk("t1 samples", feed_n - bf, 64);
    chk("t1 runs", runs - br, 1);
    chk("t1 ar0", feed_re[bf], 256);
    chk("t1 ar rest nonzero", nz_re, 0);
    chk("t1 ai nonzero", nz_im, 0);
    chk("t1 valid after", fft_valid_a, 0);
    chk("t1 ar after", fft_ar, 0);
    chk("t1 busy refill", busy, 1);

    // Sparse FIFO
    sparse = 1;
    bf = feed_n; br = runs; bp = rd_ptr; pcyc = cyc;
    push_frame(1);
    wait_feed(bf + 64, 400, "t2");
    cycles(3);
    sparse = 0;
    chk("t2 pops", rd_ptr - bp, 16);
    chk("t2 runs", runs - br, 1);
    chk("t2 sample mism", feed_mism(bf, 1), 0);
    chk("t2 slow fill", (rise_cyc - pcyc) >= 31, 1);
    chk("t2 rd_en on empty", viol, 0);

    // Backpressure
    fft_full = 1'b1;
    bf = feed_n; br = runs; bp = rd_ptr;
    push_frame(2);
    cycles(100);
    chk("t3 pops", rd_ptr - bp, 16);
    chk("t3 no feed in wait", feed_n - bf, 0);
    chk("t3 valid in wait", fft_valid_a, 0);
    chk("t3 busy in wait", busy, 1);
    fft_full = 1'b0;
    cycles(1);
    chk("t3 first valid", fft_valid_a, 1);
    chk("t3 first ar", $signed(fft_ar), -200);
    chk("t3 first ai", $signed(fft_ai), 0);
    wait_feed(bf + 64, 200, "t3");
    cycles(3);
    chk("t3 sample mism", feed_mism(bf, 2), 0);
    chk("t3 runs", runs - br, 1);
    chk("t3 feed_err", feed_err, 0);

    // Output bins with a gap at i=20
    bb = bin_n; bfd = fd_n;
    chk("t4 frame_cnt before", frame_cnt, 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        fft_valid_o = 1'b0;
        cycles(5);
      end
      fft_valid_o = 1'b1; fft_xr = 11'(i); fft_xi = 11'(-i);
      cycles(1);
    end
    fft_valid_o = 1'b0;
    cycles(3);
    m = 0;
    for (int i = 0; i < 64; i++)
      if (b_idx[bb+i] != i || b_re[bb+i] != i || b_im[bb+i] != -i) m++;
    chk("t4 bins", bin_n - bb, 64);
    chk("t4 bin mism", m, 0);
    chk("t4 bin20 idx", b_idx[bb+20], 20);
    chk("t4 done pulses", fd_n - bfd, 1);
    chk("t4 done at 63", b_fd[bb+63], 1);
    chk("t4 frame_cnt after", frame_cnt, 1);
    chk("t4 bin_valid idle", bin_valid, 0);

    // Conversion of out-of-range components
    bf = feed_n;
    sat_w = 128'h0000_0000_0000_0000_012C_0500_8000_7FFF;
    push(sat_w);
    for (int wi = 1; wi < 16; wi++) push(128'h0);
    wait_feed(bf + 64, 300, "t5");
    cycles(3);
`ifdef FFT64_FRAME_CTRL_SAT_EN
    chk("t5 re0", feed_re[bf], 1023);
    chk("t5 im0", feed_im[bf], -1024);
    chk("t5 re1", feed_re[bf+1], 1023);
`else
    chk("t5 re0", feed_re[bf], -1);
    chk("t5 im0", feed_im[bf], 0);
    chk("t5 re1", feed_re[bf+1], -768);
`endif
    chk("t5 im1", feed_im[bf+1], 300);

    // Reset in the middle of FEED
    bf = feed_n;
    push_frame(3);
    wait_feed(bf + 31, 300, "t6");
    chk("t6 sample30", feed_re[bf+30], 30);
    RST = 1'b0;
    #1;
    chk("t6 valid", fft_valid_a, 0);
    chk("t6 ar", fft_ar, 0);
    chk("t6 ai", fft_ai, 0);
    chk("t6 busy", busy, 0);
    chk("t6 rd_en", rd_en, 0);
    chk("t6 frame_cnt", frame_cnt, 0);
    chk("t6 feed_err", feed_err, 0);
    cycles(3);
    RST = 1'b1;
    bf = feed_n; br = runs;
    cycles(20);
    chk("t6 no feed before fill", feed_n - bf, 0);
    chk("t6 busy filling", busy, 1);
    bp = rd_ptr;
    push_frame(3);
    wait_feed(bf + 64, 300, "t6b");
    cycles(3);
    chk("t6 pops", rd_ptr - bp, 16);
    chk("t6 runs", runs - br, 1);
    chk("t6 sample mism", feed_mism(bf, 3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
